// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared MULDIV opcodes, HI/LO select values, cycle counts and FSM states
//   Purpose: constants shared by the interface, the arithmetic block, the top and the bench.
//   Ports:   none (package).
package muldiv_unit_pkg;

  // MULDIVMode encodings; 7..15 decode as NOTHING
  localparam logic [3:0] MULDIV_NOTHING = 4'd0;
  localparam logic [3:0] MULDIV_MULT    = 4'd1;
  localparam logic [3:0] MULDIV_MULTU   = 4'd2;
  localparam logic [3:0] MULDIV_DIV     = 4'd3;
  localparam logic [3:0] MULDIV_DIVU    = 4'd4;
  localparam logic [3:0] MULDIV_MTHI    = 4'd5;
  localparam logic [3:0] MULDIV_MTLO    = 4'd6;

  // HILOSel values
  localparam logic MULDIV_HIGH = 1'b1;
  localparam logic MULDIV_LOW  = 1'b0;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 10;
  localparam int CNT_W               = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } muldiv_state_e;

  function automatic logic is_start(input logic [3:0] mode);
    return (mode == MULDIV_MULT) || (mode == MULDIV_MULTU) ||
           (mode == MULDIV_DIV)  || (mode == MULDIV_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] mode);
    return (mode == MULDIV_DIV) || (mode == MULDIV_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - EX-stage multiply/divide bus
//   Purpose: bundles opcode, operands, read select and status/result signals.
//   Ports:   master drives MULDIVMode/A/B/HILOSel and reads Start/Busy/MULDIVOut;
//            slave is the muldiv_unit view.
interface muldiv_unit_if;
  logic [3:0]  MULDIVMode;
  logic [31:0] A;
  logic [31:0] B;
  logic        HILOSel;
  logic        Start;
  logic        Busy;
  logic [31:0] MULDIVOut;

  modport master (output MULDIVMode, A, B, HILOSel,
                  input  Start, Busy, MULDIVOut);
  modport slave  (input  MULDIVMode, A, B, HILOSel,
                  output Start, Busy, MULDIVOut);
endinterface

// File: rtl/muldiv_calc.sv
// rtl/muldiv_calc.sv - combinational signed/unsigned multiply and divide
//   Purpose: produces the HI/LO pair for MULT/MULTU/DIV/DIVU.
//   Ports:   A, B operands; mode opcode; hi/lo result; div0 = divide with zero divisor.
module muldiv_calc
  import muldiv_unit_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  mode,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        divisor;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;

  assign div0 = is_div(mode) && (B == 32'd0);

  // Substitute a harmless divisor so a zero never reaches the dividers;
  // the result is discarded by the caller when div0 is set.
  assign divisor = (B == 32'd0) ? 32'd1 : B;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign quo_s  = $signed(A) / $signed(divisor);
  assign rem_s  = $signed(A) % $signed(divisor);
  assign quo_u  = A / divisor;
  assign rem_u  = A % divisor;

  always_comb begin
    hi = 32'd0;
    lo = 32'd0;
    case (mode)
      MULDIV_MULT:  {hi, lo} = prod_s;
      MULDIV_MULTU: {hi, lo} = prod_u;
      MULDIV_DIV: begin
        hi = rem_s;
        lo = quo_s;
      end
      MULDIV_DIVU: begin
        hi = rem_u;
        lo = quo_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
//   Purpose: accepts MULT/MULTU/DIV/DIVU in IDLE, holds Busy for a fixed cycle
//            count, then commits the result to HI/LO; MTHI/MTLO write directly.
//   Ports:   clk; reset (async, active-low); bus (muldiv_unit_if.slave):
//            MULDIVMode/A/B/HILOSel in, Start (comb), Busy (reg), MULDIVOut out.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic           clk,
  input  logic           reset,
  muldiv_unit_if.slave   bus
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  muldiv_state_e    state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_r, lo_r, hi_tmp, lo_tmp;
  logic [31:0]      calc_hi, calc_lo;
  logic             calc_div0;
  logic             start;
  logic             accept;
  logic             done;

  muldiv_calc u_calc (
    .A    (bus.A),
    .B    (bus.B),
    .mode (bus.MULDIVMode),
    .hi   (calc_hi),
    .lo   (calc_lo),
    .div0 (calc_div0)
  );

  assign start         = is_start(bus.MULDIVMode);
  assign bus.Start     = start;
  assign bus.Busy      = (state == ST_RUN);
  assign bus.MULDIVOut = (bus.HILOSel == MULDIV_HIGH) ? hi_r : lo_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        // Counter is loaded with N and the exit edge is the one seen at 1,
        // giving exactly N Busy cycles; <= also covers a zero-cycle parameter.
        if (cnt <= CNT_W'(1)) begin
          done       = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
      hi_tmp <= 32'd0;
      lo_tmp <= 32'd0;
    end else if (accept) begin
      cnt <= is_div(bus.MULDIVMode) ? DIV_LOAD : MULT_LOAD;
      // Divide by zero re-latches the current HI/LO so the commit leaves them
      // unchanged; MTHI/MTLO cannot alter HI/LO while running.
      if (calc_div0) begin
        hi_tmp <= hi_r;
        lo_tmp <= lo_r;
      end else begin
        hi_tmp <= calc_hi;
        lo_tmp <= calc_lo;
      end
    end else if (state == ST_RUN) begin
      if (done) begin
        cnt  <= '0;
        hi_r <= hi_tmp;
        lo_r <= lo_tmp;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end else begin
      if (bus.MULDIVMode == MULDIV_MTHI) hi_r <= bus.A;
      if (bus.MULDIVMode == MULDIV_MTLO) lo_r <= bus.A;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_unit_if bus ();

  muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.HILOSel = 1'b1;
    #1 hi = bus.MULDIVOut;
    bus.HILOSel = 1'b0;
    #1 lo = bus.MULDIVOut;
  endtask

  task automatic check_hilo(input string tag);
    logic [31:0] h, l;
    read_hilo(h, l);
    chk({tag, " HI"}, h, mhi);
    chk({tag, " LO"}, l, mlo);
  endtask

  // Reference: architectural effect of one op, from plain arithmetic.
  task automatic model_exec(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                            output int busy, output logic st);
    longint sa, sb, ma, mb, q, r, p;
    logic [63:0] pu;
    busy = 0;
    st   = 1'b0;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    case (m)
      4'd1: begin
        busy = 5; st = 1'b1;
        p = sa * sb;
        pu = 64'(p);
        mhi = pu[63:32]; mlo = pu[31:0];
      end
      4'd2: begin
        busy = 5; st = 1'b1;
        pu = 64'(a) * 64'(b);
        mhi = pu[63:32]; mlo = pu[31:0];
      end
      4'd3: begin
        busy = 10; st = 1'b1;
        if (b != 32'd0) begin
          ma = (sa < 0) ? -sa : sa;
          mb = (sb < 0) ? -sb : sb;
          q  = ma / mb;
          if ((sa < 0) != (sb < 0)) q = -q;
          r  = sa - q * sb;
          mhi = 32'(r); mlo = 32'(q);
        end
      end
      4'd4: begin
        busy = 10; st = 1'b1;
        if (b != 32'd0) begin
          mlo = a / b;
          mhi = a - mlo * b;
        end
      end
      4'd5: mhi = a;
      4'd6: mlo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int   eb, n;
    logic est;
    model_exec(m, a, b, eb, est);
    bus.MULDIVMode = m; bus.A = a; bus.B = b;
    #1 chk({tag, " start"}, {31'd0, bus.Start}, {31'd0, est});
    step();
    bus.MULDIVMode = MULDIV_NOTHING;
    n = 0;
    while (bus.Busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk({tag, " busy_cycles"}, n, eb);
    check_hilo(tag);
  endtask

  initial begin
    logic [31:0] h, l, a1, b1, a2, b2, ra, rb;
    logic [3:0]  rm;
    int          n, eb;
    logic        est;

    rst_n = 1'b0;
    bus.MULDIVMode = MULDIV_NOTHING; bus.A = 32'd0; bus.B = 32'd0; bus.HILOSel = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset busy", {31'd0, bus.Busy}, 32'd0);
    check_hilo("reset");
    rst_n = 1'b1;
    step();

    // signed multiply -2 * 3
    run_op(MULDIV_MULT, 32'hFFFFFFFE, 32'd3, "mult_neg");
    read_hilo(h, l);
    chk("mult_neg const HI", h, 32'hFFFFFFFF);
    chk("mult_neg const LO", l, 32'hFFFFFFFA);

    // signed divide -7 / 2
    run_op(MULDIV_DIV, 32'hFFFFFFF9, 32'd2, "div_neg");
    read_hilo(h, l);
    chk("div_neg const HI", h, 32'hFFFFFFFF);
    chk("div_neg const LO", l, 32'hFFFFFFFD);

    // MTHI/MTLO then divide by zero
    run_op(MULDIV_MTHI, 32'h11, 32'd0, "mthi");
    run_op(MULDIV_MTLO, 32'h22, 32'd0, "mtlo");
    run_op(MULDIV_DIVU, 32'd7, 32'd0, "divu_zero");
    read_hilo(h, l);
    chk("divu_zero const HI", h, 32'h11);
    chk("divu_zero const LO", l, 32'h22);

    // MTHI at cycle 2 of a MULTU is ignored
    model_exec(MULDIV_MULTU, 32'hFFFFFFFF, 32'd2, eb, est);
    bus.MULDIVMode = MULDIV_MULTU; bus.A = 32'hFFFFFFFF; bus.B = 32'd2;
    step();
    bus.MULDIVMode = MULDIV_NOTHING;
    step();
    bus.MULDIVMode = MULDIV_MTHI; bus.A = 32'h55;
    #1 chk("mthi_in_run start", {31'd0, bus.Start}, 32'd0);
    step();
    bus.MULDIVMode = MULDIV_NOTHING;
    n = 2;
    while (bus.Busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk("mthi_in_run busy_cycles", n, eb);
    read_hilo(h, l);
    chk("mthi_in_run HI", h, 32'h1);
    chk("mthi_in_run LO", l, 32'hFFFFFFFE);

    // reset at cycle 3 of a MULT
    bus.MULDIVMode = MULDIV_MULT; bus.A = 32'd5; bus.B = 32'd7;
    step();
    bus.MULDIVMode = MULDIV_NOTHING;
    step();
    step();
    chk("pre_reset busy", {31'd0, bus.Busy}, 32'd1);
    rst_n = 1'b0;
    #1 chk("mid_reset busy", {31'd0, bus.Busy}, 32'd0);
    mhi = 32'd0; mlo = 32'd0;
    step();
    rst_n = 1'b1;
    check_hilo("after_reset");
    run_op(MULDIV_MULT, 32'hFFFFFFFC, 32'd6, "post_reset_mult");

    // back-to-back MULT with Start held across completion
    a1 = 32'd1234; b1 = 32'hFFFF0000; a2 = 32'h7FFFFFFF; b2 = 32'h7FFFFFFF;
    model_exec(MULDIV_MULT, a1, b1, eb, est);
    bus.MULDIVMode = MULDIV_MULT; bus.A = a1; bus.B = b1;
    step();
    bus.A = a2; bus.B = b2;
    n = 0;
    while (bus.Busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk("b2b first busy_cycles", n, eb);
    chk("b2b gap start", {31'd0, bus.Start}, 32'd1);
    check_hilo("b2b gap");
    step();
    chk("b2b second accepted", {31'd0, bus.Busy}, 32'd1);
    bus.MULDIVMode = MULDIV_NOTHING;
    model_exec(MULDIV_MULT, a2, b2, eb, est);
    n = 1;
    step();
    while (bus.Busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk("b2b second busy_cycles", n, eb);
    check_hilo("b2b second");

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rm = 4'($urandom_range(1, 8));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) ra = 32'($signed($urandom_range(0, 200)) - 100);
      if (rm == MULDIV_DIV && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
      run_op(rm, ra, rb, $sformatf("rand%0d_m%0d", i, rm));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
